// File: rtl/skewed_fifo_bank.sv
// Bank of one vector FIFO and NUM_ROWS row FIFOs, written by target select and drained
// column-by-column with a diagonal pop skew (row k pops k cycles after row 0).
module skewed_fifo_bank #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int NUM_ROWS = 4,
    parameter int SEL_W    = $clog2(NUM_ROWS + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sync_clear,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         wr_en,
    input  logic [SEL_W-1:0]             wr_sel,
    input  logic                         pop,
    input  logic                         recirculate,
    output logic [DATA_W-1:0]            vec_out,
    output logic                         vec_valid,
    output logic [NUM_ROWS*DATA_W-1:0]   row_out,
    output logic [NUM_ROWS-1:0]          row_valid,
    output logic [NUM_ROWS:0]            full_flags,
    output logic [NUM_ROWS:0]            empty_flags,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int NF     = NUM_ROWS + 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int SKEW_W = (NUM_ROWS > 1) ? NUM_ROWS - 1 : 1;

    logic [DATA_W-1:0] mem [NF][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NF];
    logic [PTR_W-1:0]  rd_ptr [NF];
    logic [CNT_W-1:0]  count [NF];
    logic [CNT_W-1:0]  count_next [NF];
    logic [DATA_W-1:0] push_data [NF];
    logic [DATA_W-1:0] out_reg [NF];
    logic [SKEW_W-1:0] skew;
    logic [NF-1:0]     pop_req;
    logic [NF-1:0]     do_pop;
    logic [NF-1:0]     do_push;
    logic [NF-1:0]     push_drop;
    logic [NF-1:0]     pop_miss;
    logic [NF-1:0]     valid_reg;
    logic              want_push;

    // Index 0 is the vector FIFO; index k+1 is row k, which pops from the skew pipe.
    always_comb begin
        pop_req   = '0;
        pop_req[0] = pop;
        pop_req[1] = pop;
        for (int k = 1; k < NUM_ROWS; k++) pop_req[k+1] = skew[k-1];
        do_pop    = '0;
        do_push   = '0;
        push_drop = '0;
        pop_miss  = '0;
        want_push = 1'b0;
        for (int f = 0; f < NF; f++) begin
            push_data[f]  = wr_data;
            count_next[f] = count[f];
            do_pop[f]     = pop_req[f] && (count[f] != '0);
            pop_miss[f]   = pop_req[f] && (count[f] == '0);
            want_push     = wr_en && (wr_sel == SEL_W'(f));
            if (f == 0 && do_pop[0] && recirculate) begin
                do_push[0]   = 1'b1;
                push_data[0] = mem[0][rd_ptr[0]];
                push_drop[0] = want_push;
            end else begin
                do_push[f]   = want_push && ((count[f] != CNT_W'(DEPTH)) || do_pop[f]);
                push_drop[f] = want_push && !do_push[f];
            end
            case ({do_push[f], do_pop[f]})
                2'b10:   count_next[f] = count[f] + 1'b1;
                2'b01:   count_next[f] = count[f] - 1'b1;
                default: count_next[f] = count[f];
            endcase
        end
    end

    // Storage is deliberately left out of reset; only pointers/counts define validity.
    always_ff @(posedge clk) begin
        for (int f = 0; f < NF; f++) begin
            if (!reset && !sync_clear && do_push[f]) mem[f][wr_ptr[f]] <= push_data[f];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skew        <= '0;
            valid_reg   <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            full_flags  <= '0;
            empty_flags <= '1;
            for (int f = 0; f < NF; f++) begin
                wr_ptr[f]  <= '0;
                rd_ptr[f]  <= '0;
                count[f]   <= '0;
                out_reg[f] <= '0;
            end
        end else if (sync_clear) begin
            skew        <= '0;
            valid_reg   <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            full_flags  <= '0;
            empty_flags <= '1;
            for (int f = 0; f < NF; f++) begin
                wr_ptr[f]  <= '0;
                rd_ptr[f]  <= '0;
                count[f]   <= '0;
                out_reg[f] <= '0;
            end
        end else begin
            skew[0] <= pop;
            for (int i = 1; i < SKEW_W; i++) skew[i] <= skew[i-1];
            valid_reg <= do_pop;
            if (|push_drop) overflow <= 1'b1;
            if (|pop_miss) underflow <= 1'b1;
            for (int f = 0; f < NF; f++) begin
                if (do_push[f]) wr_ptr[f] <= wr_ptr[f] + 1'b1;
                if (do_pop[f]) begin
                    rd_ptr[f]  <= rd_ptr[f] + 1'b1;
                    out_reg[f] <= mem[f][rd_ptr[f]];
                end
                count[f]       <= count_next[f];
                full_flags[f]  <= (count_next[f] == CNT_W'(DEPTH));
                empty_flags[f] <= (count_next[f] == '0);
            end
        end
    end

    assign vec_out   = out_reg[0];
    assign vec_valid = valid_reg[0];

    for (genvar k = 0; k < NUM_ROWS; k++) begin : g_rows
        assign row_out[k*DATA_W +: DATA_W] = out_reg[k+1];
        assign row_valid[k]                = valid_reg[k+1];
    end

endmodule
